// File: rtl/btn_mode_conditioner.sv
// Push-button / mode-switch front end: synchronise, debounce, one-shot step strobe, frozen mode.
// Optional hold-to-repeat strobes are compiled in with `define AUTO_REPEAT_EN.
module btn_mode_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnC,
    input  logic [1:0] sw,
    output logic       step,
    output logic       btn_level,
    output logic [1:0] mode
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HELD, RPT_WAIT, RPT} state_t;
    logic [RW-1:0] rcnt, rcnt_next;
`else
    typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

    state_t        state, state_next;
    logic          btn_m, btn_s;
    logic [1:0]    sw_m, sw_s;
    logic [CW-1:0] cnt;
    logic          toggle, rise, fall, step_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= btnC;
            btn_s <= btn_m;
            sw_m  <= sw;
            sw_s  <= sw_m;
        end
    end

    // Level flips on the same edge the count would reach DEBOUNCE_CYCLES.
    assign toggle = (btn_s != btn_level) && (cnt == DB_LAST);
    assign rise   = toggle && !btn_level;
    assign fall   = toggle && btn_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (btn_s != btn_level) begin
            if (cnt == DB_LAST) begin
                cnt       <= '0;
                btn_level <= ~btn_level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_next  = '0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HELD;
                    step_next  = 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_next = IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else begin
                    // Count the HELD cycle so RPT_WAIT fires REPEAT_DELAY after the press strobe.
                    state_next = RPT_WAIT;
                    rcnt_next  = rcnt + 1'b1;
                end
            end
            RPT_WAIT: begin
                if (fall) begin
                    state_next = IDLE;
                end else if (rcnt == DELAY_LAST) begin
                    state_next = RPT;
                    step_next  = 1'b1;
                end else begin
                    rcnt_next = rcnt + 1'b1;
                end
            end
            RPT: begin
                if (fall) begin
                    state_next = IDLE;
                end else if (rcnt == PERIOD_LAST) begin
                    step_next = 1'b1;
                end else begin
                    rcnt_next = rcnt + 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= 1'b0;
            mode  <= '0;
`ifdef AUTO_REPEAT_EN
            rcnt  <= '0;
`endif
        end else begin
            state <= state_next;
            step  <= step_next;
            // A switch change coinciding with the press edge is deliberately not captured.
            if (state == IDLE && !rise) begin
                mode <= sw_s;
            end
`ifdef AUTO_REPEAT_EN
            rcnt  <= rcnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_btn_mode_conditioner.sv
// Directed self-checking bench for btn_mode_conditioner (DEBOUNCE=4, DELAY=20, PERIOD=8).
module tb_btn_mode_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnC = 1'b0;
    logic [1:0] sw = 2'b00;
    logic       step, btn_level;
    logic [1:0] mode;

    int vectors = 0;
    int errors  = 0;

    btn_mode_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btnC(btnC),
        .sw(sw),
        .step(step),
        .btn_level(btn_level),
        .mode(mode)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_idle();
        btnC = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btnC = 1'b1;
        sw = 2'b11;
        #12;
        vectors++;
        if (step !== 1'b0) begin errors++; $display("FAIL reset_step got=%b exp=0", step); end
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level got=%b exp=0", btn_level); end
        vectors++;
        if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=00", mode); end
        btnC = 1'b0;
        sw = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        settle_idle();
    endtask

    task automatic test_clean_press();
        logic exp_step;
        sw = 2'b01;
        btnC = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            exp_step = (t == 6);
`ifdef AUTO_REPEAT_EN
            exp_step = exp_step || (t == 26);
`endif
            vectors++;
            if (step !== exp_step) begin errors++; $display("FAIL press_step t=%0d got=%b exp=%b", t, step, exp_step); end
            if (t == 5 || t == 6) begin
                vectors++;
                if (btn_level !== (t == 6)) begin errors++; $display("FAIL press_level t=%0d got=%b exp=%b", t, btn_level, (t == 6)); end
            end
            if (t == 6) begin
                vectors++;
                if (mode !== 2'b01) begin errors++; $display("FAIL press_mode got=%b exp=01", mode); end
            end
        end
        btnC = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            tick();
            exp_step = 1'b0;
`ifdef AUTO_REPEAT_EN
            exp_step = (r == 4);
`endif
            vectors++;
            if (step !== exp_step) begin errors++; $display("FAIL release_step r=%0d got=%b exp=%b", r, step, exp_step); end
            if (r == 5 || r == 6) begin
                vectors++;
                if (btn_level !== (r == 5)) begin errors++; $display("FAIL release_level r=%0d got=%b exp=%b", r, btn_level, (r == 5)); end
            end
        end
        settle_idle();
    endtask

    task automatic test_bounce();
        int steps = 0;
        for (int c = 0; c < 12; c++) begin
            btnC = ((c / 2) % 2 == 0);
            tick();
            vectors++;
            if (step !== 1'b0) begin errors++; $display("FAIL bounce_early c=%0d got=%b exp=0", c, step); end
        end
        btnC = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (step === 1'b1) steps++;
            vectors++;
            if (step !== (t == 6)) begin errors++; $display("FAIL bounce_step t=%0d got=%b exp=%b", t, step, (t == 6)); end
        end
        vectors++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL bounce_level got=%b exp=1", btn_level); end
        btnC = 1'b0; tick();
        btnC = 1'b1; tick();
        btnC = 1'b0;
        for (int t = 0; t < 14; t++) begin
            tick();
            if (step === 1'b1) steps++;
        end
        vectors++;
        if (steps != 1) begin errors++; $display("FAIL bounce_count got=%0d exp=1", steps); end
        vectors++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL bounce_release got=%b exp=0", btn_level); end
        settle_idle();
    endtask

    task automatic test_glitch();
        btnC = 1'b1;
        for (int t = 0; t < 15; t++) begin
            if (t == 3) btnC = 1'b0;
            tick();
            vectors++;
            if (step !== 1'b0 || btn_level !== 1'b0) begin
                errors++;
                $display("FAIL glitch t=%0d got step=%b level=%b exp 0 0", t, step, btn_level);
            end
        end
    endtask

    task automatic test_mode_freeze();
        sw = 2'b10;
        settle_idle();
        btnC = 1'b1;
        for (int t = 0; t < 6; t++) tick();
        vectors++;
        if (step !== 1'b1 || mode !== 2'b10) begin
            errors++; $display("FAIL freeze_press got step=%b mode=%b exp 1 10", step, mode);
        end
        sw = 2'b11;
        for (int t = 0; t < 10; t++) begin
            tick();
            vectors++;
            if (mode !== 2'b10) begin errors++; $display("FAIL freeze_hold t=%0d got=%b exp=10", t, mode); end
        end
        btnC = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        vectors++;
        if (btn_level !== 1'b0 || mode !== 2'b10) begin
            errors++; $display("FAIL freeze_release got level=%b mode=%b exp 0 10", btn_level, mode);
        end
        tick(); tick();
        vectors++;
        if (mode !== 2'b11) begin errors++; $display("FAIL freeze_after got=%b exp=11", mode); end
        settle_idle();
        btnC = 1'b1;
        for (int t = 0; t < 6; t++) tick();
        vectors++;
        if (step !== 1'b1 || mode !== 2'b11) begin
            errors++; $display("FAIL freeze_repress got step=%b mode=%b exp 1 11", step, mode);
        end
        settle_idle();
    endtask

    task automatic test_simultaneous();
        sw = 2'b00;
        settle_idle();
        btnC = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        sw = 2'b11;
        for (int t = 0; t < 3; t++) tick();
        vectors++;
        if (step !== 1'b1 || mode !== 2'b00) begin
            errors++; $display("FAIL simul_edge got step=%b mode=%b exp 1 00", step, mode);
        end
        for (int t = 0; t < 5; t++) tick();
        vectors++;
        if (mode !== 2'b00) begin errors++; $display("FAIL simul_hold got=%b exp=00", mode); end
        settle_idle();
    endtask

    task automatic test_reset_mid();
        sw = 2'b11;
        settle_idle();
        btnC = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (step !== 1'b0 || btn_level !== 1'b0 || mode !== 2'b00) begin
            errors++; $display("FAIL rst_count got step=%b level=%b mode=%b exp 0 0 00", step, btn_level, mode);
        end
        rst = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t >= 5) begin
                vectors++;
                if (step !== (t == 6)) begin errors++; $display("FAIL rst_restep1 t=%0d got=%b exp=%b", t, step, (t == 6)); end
            end
        end
        vectors++;
        if (mode !== 2'b11) begin errors++; $display("FAIL rst_mode got=%b exp=11", mode); end
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (step !== 1'b0 || btn_level !== 1'b0 || mode !== 2'b00) begin
            errors++; $display("FAIL rst_held got step=%b level=%b mode=%b exp 0 0 00", step, btn_level, mode);
        end
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            vectors++;
            if (step !== (t == 6)) begin errors++; $display("FAIL rst_restep2 t=%0d got=%b exp=%b", t, step, (t == 6)); end
        end
        settle_idle();
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        logic exp_step;
        btnC = 1'b1;
        for (int t = 0; t < 6; t++) tick();
        vectors++;
        if (step !== 1'b1) begin errors++; $display("FAIL rpt_press got=%b exp=1", step); end
        for (int k = 1; k <= 70; k++) begin
            if (k == 54) btnC = 1'b0;
            tick();
            exp_step = (k == 20) || (k == 28) || (k == 36) || (k == 44) || (k == 52);
            vectors++;
            if (step !== exp_step) begin errors++; $display("FAIL rpt_step k=%0d got=%b exp=%b", k, step, exp_step); end
            if (k == 58 || k == 59) begin
                vectors++;
                if (btn_level !== (k == 58)) begin errors++; $display("FAIL rpt_level k=%0d got=%b exp=%b", k, btn_level, (k == 58)); end
            end
        end
        settle_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_mode_freeze();
        test_simultaneous();
        test_reset_mid();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
